// File: rtl/pb_bit_encoder_if.sv
// Push-button encoder bus: raw button inputs toward the encoder, decoded strobes back.
// The encoder takes the slave modport; the driver of the buttons takes the master modport.
interface pb_bit_encoder_if;
    logic       pb_zero;
    logic       pb_one;
    logic       pb_lock;
    logic       bit_valid;
    logic       bit_val;
    logic       frame_done;
    logic       lock_req;
    logic [2:0] bit_count;
    logic       timeout;
    logic       conflict;

    modport master (
        output pb_zero, pb_one, pb_lock,
        input  bit_valid, bit_val, frame_done, lock_req, bit_count, timeout, conflict
    );

    modport slave (
        input  pb_zero, pb_one, pb_lock,
        output bit_valid, bit_val, frame_done, lock_req, bit_count, timeout, conflict
    );
endinterface

// File: rtl/pb_bit_encoder.sv
// Turns three raw push buttons into debounced data-bit, frame, lock and conflict strobes.
// state | meaning
// IDLE  | no partial frame, bit count 0, idle timer held at 0
// ENTRY | partial frame in progress, idle timer running toward timeout
module pb_bit_encoder #(
    parameter int DB_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES = 500,
    parameter int FRAME_LEN      = 6
) (
    input logic             clk,
    input logic             rst,
    pb_bit_encoder_if.slave bus
);
    localparam logic [7:0]  DB_LAST    = 8'(DB_CYCLES - 1);
    localparam logic [15:0] IDLE_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  FRAME_LAST = 3'(FRAME_LEN - 1);

    typedef enum logic {IDLE, ENTRY} state_t;

    logic [2:0]      raw;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      lvl_q, lvl_d, lvl_prev_q;
    logic [2:0][7:0] db_cnt_q, db_cnt_d;
    logic [2:0]      rise;

    state_t      state_q, state_d;
    logic [2:0]  frame_cnt_q, frame_cnt_d;
    logic [15:0] idle_q, idle_d;
    logic [2:0]  bit_count_q;

    logic bit_valid_q, bit_valid_d;
    logic bit_val_q, bit_val_d;
    logic frame_done_q, frame_done_d;
    logic lock_req_q, lock_req_d;
    logic timeout_q, timeout_d;
    logic conflict_q, conflict_d;

    logic data_ev, data_clash, accept;

    // Channel order: 0 = zero, 1 = one, 2 = lock.
    assign raw  = {bus.pb_lock, bus.pb_one, bus.pb_zero};
    assign rise = lvl_q & ~lvl_prev_q;

    always_comb begin
        lvl_d    = lvl_q;
        db_cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    lvl_d[i] = ~lvl_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // A data press is rejected when the other data button is (or just became) held.
    assign data_ev    = rise[0] | rise[1];
    assign data_clash = (rise[0] & lvl_q[1]) | (rise[1] & lvl_q[0]);
    assign accept     = data_ev & ~data_clash & ~rise[2];

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        idle_d       = idle_q;
        bit_valid_d  = accept;
        bit_val_d    = accept & rise[1];
        lock_req_d   = rise[2];
        conflict_d   = data_ev & (data_clash | rise[2]);
        frame_done_d = 1'b0;
        timeout_d    = 1'b0;

        if (rise[2]) begin
            state_d     = IDLE;
            frame_cnt_d = '0;
            idle_d      = '0;
        end else if (accept) begin
            idle_d = '0;
            if (frame_cnt_q == FRAME_LAST) begin
                frame_done_d = 1'b1;
                state_d      = IDLE;
                frame_cnt_d  = '0;
            end else begin
                state_d     = ENTRY;
                frame_cnt_d = frame_cnt_q + 3'd1;
            end
        end else begin
            case (state_q)
                ENTRY: begin
                    if (idle_q == IDLE_LAST) begin
                        timeout_d   = 1'b1;
                        state_d     = IDLE;
                        frame_cnt_d = '0;
                        idle_d      = '0;
                    end else begin
                        idle_d = idle_q + 16'd1;
                    end
                end
                default: idle_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            lvl_q        <= '0;
            lvl_prev_q   <= '0;
            db_cnt_q     <= '0;
            state_q      <= IDLE;
            frame_cnt_q  <= '0;
            idle_q       <= '0;
            bit_count_q  <= '0;
            bit_valid_q  <= 1'b0;
            bit_val_q    <= 1'b0;
            frame_done_q <= 1'b0;
            lock_req_q   <= 1'b0;
            timeout_q    <= 1'b0;
            conflict_q   <= 1'b0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            lvl_q        <= lvl_d;
            lvl_prev_q   <= lvl_q;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            idle_q       <= idle_d;
            bit_count_q  <= frame_cnt_q;
            bit_valid_q  <= bit_valid_d;
            bit_val_q    <= bit_val_d;
            frame_done_q <= frame_done_d;
            lock_req_q   <= lock_req_d;
            timeout_q    <= timeout_d;
            conflict_q   <= conflict_d;
        end
    end

    // bit_count trails the strobes by one cycle so it reads 0 right after frame_done.
    assign bus.bit_valid  = bit_valid_q;
    assign bus.bit_val    = bit_val_q;
    assign bus.frame_done = frame_done_q;
    assign bus.lock_req   = lock_req_q;
    assign bus.bit_count  = bit_count_q;
    assign bus.timeout    = timeout_q;
    assign bus.conflict   = conflict_q;
endmodule

// File: tb/tb_pb_bit_encoder.sv
// Scoreboard bench for pb_bit_encoder: stimulus pushes hand-computed strobe events,
// a negedge monitor pops and compares them whenever any strobe is seen.
module tb_pb_bit_encoder;
    localparam logic [5:0] F_BIT0 = 6'b100000;
    localparam logic [5:0] F_BIT1 = 6'b110000;
    localparam logic [5:0] F_FD   = 6'b001000;
    localparam logic [5:0] F_LOCK = 6'b000100;
    localparam logic [5:0] F_TO   = 6'b000010;
    localparam logic [5:0] F_CF   = 6'b000001;

    typedef struct {
        int         c;
        logic [5:0] f;
        logic [2:0] bc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    exp_t       q[$];
    exp_t       e;
    logic [5:0] act;
    logic       bc_pend = 1'b0;
    logic [2:0] bc_exp = '0;

    pb_bit_encoder_if bus ();

    pb_bit_encoder #(
        .DB_CYCLES      (4),
        .TIMEOUT_CYCLES (20),
        .FRAME_LEN      (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            bc_pend = 1'b0;
        end else begin
            if (bc_pend) begin
                checks++;
                if (bus.bit_count !== bc_exp) begin
                    fails++;
                    $display("FAIL bit_count_after_event: cycle %0d got %0d expected %0d", cyc, bus.bit_count, bc_exp);
                end
                bc_pend = 1'b0;
            end
            act = {bus.bit_valid, bus.bit_valid & bus.bit_val, bus.frame_done,
                   bus.lock_req, bus.timeout, bus.conflict};
            if (act !== 6'b0) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_strobe: cycle %0d got flags %b expected none", cyc, act);
                end else begin
                    e = q.pop_front();
                    if (e.c != cyc || e.f !== act) begin
                        fails++;
                        $display("FAIL strobe_event: got cycle %0d flags %b expected cycle %0d flags %b",
                                 cyc, act, e.c, e.f);
                    end
                    bc_pend = 1'b1;
                    bc_exp  = e.bc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [5:0] f, input logic [2:0] bc);
        exp_t x;
        x.c  = c;
        x.f  = f;
        x.bc = bc;
        q.push_back(x);
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic set_pb(input int ch, input logic v);
        case (ch)
            0:       bus.pb_zero = v;
            1:       bus.pb_one  = v;
            default: bus.pb_lock = v;
        endcase
    endtask

    // Clean press: held 8 edges, released 9; next press starts 17 edges later.
    task automatic data_press(input int ch, input logic [5:0] f, input logic [2:0] bc, output int n);
        tick();
        n = cyc;
        set_pb(ch, 1'b1);
        push(n + 7, f, bc);
        repeat (7) tick();
        set_pb(ch, 1'b0);
        repeat (9) tick();
    endtask

    function automatic int out_word();
        return int'({bus.bit_valid, bus.bit_val, bus.frame_done, bus.lock_req,
                     bus.timeout, bus.conflict, bus.bit_count});
    endfunction

    initial begin
        int n, n1, r;
        bus.pb_zero = 1'b0;
        bus.pb_one  = 1'b0;
        bus.pb_lock = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", out_word(), 0);
        rst = 1'b0;
        repeat (3) tick();

        // Single long press of one, then the partial frame times out.
        tick();
        n = cyc;
        bus.pb_one = 1'b1;
        push(n + 7, F_BIT1, 3'd1);
        push(n + 27, F_TO, 3'd0);
        repeat (10) tick();
        bus.pb_one = 1'b0;
        repeat (30) tick();

        // Glitches shorter than the debounce window.
        for (int i = 0; i < 5; i++) begin
            bus.pb_zero = 1'b1;
            repeat (3) tick();
            bus.pb_zero = 1'b0;
            repeat (3) tick();
        end
        repeat (10) tick();
        check("glitch_bit_count", int'(bus.bit_count), 0);
        check("glitch_queue_empty", q.size(), 0);

        // Full frame 1,0,1,0,1,1.
        data_press(1, F_BIT1, 3'd1, n);
        data_press(0, F_BIT0, 3'd2, n);
        data_press(1, F_BIT1, 3'd3, n);
        data_press(0, F_BIT0, 3'd4, n);
        data_press(1, F_BIT1, 3'd5, n);
        data_press(1, F_BIT1 | F_FD, 3'd0, n);
        repeat (25) tick();

        // Simultaneous zero+one mid-frame, then timeout from the one accepted bit.
        data_press(0, F_BIT0, 3'd1, n1);
        tick();
        n = cyc;
        bus.pb_zero = 1'b1;
        bus.pb_one  = 1'b1;
        push(n + 7, F_CF, 3'd1);
        push(n1 + 27, F_TO, 3'd0);
        repeat (7) tick();
        bus.pb_zero = 1'b0;
        bus.pb_one  = 1'b0;
        repeat (20) tick();

        // Two bits, idle timeout, then a fresh frame up to three bits and a lock.
        data_press(1, F_BIT1, 3'd1, n);
        data_press(0, F_BIT0, 3'd2, n);
        push(n + 27, F_TO, 3'd0);
        repeat (15) tick();
        data_press(1, F_BIT1, 3'd1, n);
        data_press(0, F_BIT0, 3'd2, n);
        data_press(1, F_BIT1, 3'd3, n);
        data_press(2, F_LOCK, 3'd0, n);

        // Lock and data pressed together.
        tick();
        n = cyc;
        bus.pb_lock = 1'b1;
        bus.pb_zero = 1'b1;
        push(n + 7, F_LOCK | F_CF, 3'd0);
        repeat (7) tick();
        bus.pb_lock = 1'b0;
        bus.pb_zero = 1'b0;
        repeat (12) tick();

        // One pressed while zero is still held down.
        tick();
        n = cyc;
        bus.pb_zero = 1'b1;
        push(n + 7, F_BIT0, 3'd1);
        push(n + 16, F_CF, 3'd1);
        push(n + 27, F_TO, 3'd0);
        repeat (9) tick();
        bus.pb_one = 1'b1;
        repeat (11) tick();
        bus.pb_zero = 1'b0;
        bus.pb_one  = 1'b0;
        repeat (15) tick();

        // Reset mid-frame with one held through reset release.
        data_press(1, F_BIT1, 3'd1, n);
        data_press(0, F_BIT0, 3'd2, n);
        tick();
        bus.pb_one = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        #2;
        check("midframe_reset_outputs", out_word(), 0);
        repeat (3) tick();
        tick();
        r = cyc;
        rst = 1'b0;
        push(r + 7, F_BIT1, 3'd1);
        push(r + 27, F_TO, 3'd0);
        repeat (10) tick();
        bus.pb_one = 1'b0;
        repeat (30) tick();

        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got time limit expired expected test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pb_bit_encoder.md
PB_BIT_ENCODER -- requirements
Module: pb_bit_encoder

Interface
REQ-001 Parameter: DB_CYCLES, default 4, consecutive stable cycles needed to accept a level change (range 1-255).
REQ-002 Parameter: TIMEOUT_CYCLES, default 500, idle cycles after which a partial entry is discarded (range 2-65535).
REQ-003 Parameter: FRAME_LEN, default 6, accepted bits per complete code entry (range 1-7).
REQ-004 Port: clk  in  1  system clock, 100 Hz board clock.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: pb_zero  in  1  raw, unsynchronised "enter 0" button.
REQ-007 Port: pb_one  in  1  raw, unsynchronised "enter 1" button.
REQ-008 Port: pb_lock  in  1  raw, unsynchronised "arm lock" button.
REQ-009 Port: bit_valid  out  1  one-cycle strobe, one accepted data bit.
REQ-010 Port: bit_val  out  1  value of the accepted bit, valid only while bit_valid=1.
REQ-011 Port: frame_done  out  1  one-cycle strobe, coincident with the FRAME_LEN-th bit_valid.
REQ-012 Port: lock_req  out  1  one-cycle strobe, accepted lock press.
REQ-013 Port: bit_count  out  3  number of bits accepted in the current frame, 0..FRAME_LEN-1.
REQ-014 Port: timeout  out  1  one-cycle strobe, partial frame discarded.
REQ-015 Port: conflict  out  1  one-cycle strobe, press rejected.

Function
REQ-016 Each raw input SHALL pass through its own 2-flop synchroniser; no raw input drives any other logic.
REQ-017 Each channel SHALL have a debounced level register and a stability counter; the counter SHALL increment while the synchronised value differs from the debounced level and clear to 0 when they match.
REQ-018 The debounced level SHALL toggle, and the counter SHALL clear, on the cycle the counter reaches DB_CYCLES; any glitch shorter than DB_CYCLES cycles SHALL produce no event.
REQ-019 A press event SHALL be the rising edge of a debounced level; falling edges SHALL produce no output.
REQ-020 Latency: a raw level held high from edge N SHALL produce its strobe registered at edge N+DB_CYCLES+3.
REQ-021 All strobe outputs SHALL be registered and SHALL be high for exactly one cycle per event.
REQ-022 A zero or one press event SHALL give bit_valid=1 with bit_val=0 or 1 respectively, only if the other data channel's debounced level is low.
REQ-023 If zero and one press events occur in the same cycle, or one occurs while the other is debounced high: no bit_valid, conflict=1, bit_count unchanged.
REQ-024 If a lock press event and a data press event occur in the same cycle: lock_req=1, conflict=1, data bit dropped.
REQ-025 FSM states: IDLE (bit_count=0) and ENTRY (0<bit_count<FRAME_LEN).
REQ-026 IDLE->ENTRY on an accepted bit when FRAME_LEN>1; with FRAME_LEN=1 every accepted bit SHALL assert frame_done and stay in IDLE.
REQ-027 In ENTRY, each accepted bit SHALL increment bit_count.
REQ-028 ENTRY->IDLE on the FRAME_LEN-th accepted bit: frame_done=1 in the same cycle as that bit_valid, bit_count=0 on the next cycle.
REQ-029 In ENTRY, an idle counter SHALL count cycles since the last accepted bit, and SHALL clear on every accepted bit.
REQ-030 When the idle counter reaches TIMEOUT_CYCLES: timeout=1, bit_count=0, state IDLE.
REQ-031 The idle counter SHALL hold at 0 in IDLE; timeout SHALL never assert in IDLE.
REQ-032 lock_req SHALL clear bit_count to 0 and force IDLE in both states.
REQ-033 An accepted bit and a timeout expiry in the same cycle: the bit wins, and timeout is not asserted.

Reset
REQ-034 While rst=1: all synchroniser, debounced-level, counter and strobe registers = 0; state IDLE; bit_count=0.
REQ-035 A button held through reset deassertion SHALL be debounced normally and generate exactly one press event.
REQ-036 Reset mid-frame SHALL discard the partial frame with no frame_done or timeout strobe.

Verification (DB_CYCLES=4, TIMEOUT_CYCLES=20, FRAME_LEN=6)
REQ-037 pb_one high 10 cycles from edge 0 -> bit_valid=1, bit_val=1 at edge 7 only; bit_count=1 at edge 8.
REQ-038 pb_zero pulses 3 cycles high, 3 low, repeated 5 times -> no bit_valid and no conflict ever.
REQ-039 Six clean presses 1,0,1,0,1,1 -> six bit_valid strobes with those values; frame_done coincident with the 6th; bit_count sequence 1,2,3,4,5,0.
REQ-040 pb_zero and pb_one raised on the same edge -> conflict=1 for one cycle, no bit_valid, bit_count unchanged.
REQ-041 Two accepted bits, then 20 idle cycles -> timeout=1 for one cycle, bit_count=0; the next press -> bit_count=1.
REQ-042 Three accepted bits, then a pb_lock press -> lock_req=1, bit_count=0; rst pulsed mid-frame -> all outputs 0 immediately.
